// File: rtl/packet_word_tx.sv
// packet_word_tx: FIFO-buffered packer of {addr,data} packets onto a 16-bit bus word
module packet_word_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_addr,
  input  logic [7:0]               in_data,
  input  logic                     in_pkt_vld,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_word,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         tx_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd, wr, rd_nxt;
  logic [PW:0]   level_nxt;
  logic [15:0]   head_nxt;
  logic          acc, push, drop, pop;
  assign in_ready  = rst_n && !flush && (level != (PW+1)'(DEPTH));
  assign acc       = in_valid && in_ready;
  assign push      = acc && in_pkt_vld;
  assign drop      = acc && !in_pkt_vld;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign rd_nxt    = rd + PW'(pop);
  assign level_nxt = level + (PW+1)'(push) - (PW+1)'(pop);
  // next head word: a packet written this cycle into the slot becoming head bypasses the array
  assign head_nxt  = (level_nxt == '0) ? 16'h0000 :
                     (push && rd_nxt == wr) ? {in_addr, in_data} : mem[rd_nxt];
  // storage array, written on every accepted valid packet
  always_ff @(posedge clk)
    if (push) mem[wr] <= {in_addr, in_data};
  // pointers, occupancy, registered head word and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd       <= '0;
      wr       <= '0;
      level    <= '0;
      out_word <= '0;
      tx_cnt   <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      rd       <= '0;
      wr       <= '0;
      level    <= '0;
      out_word <= '0;
    end else begin
      rd       <= rd_nxt;
      wr       <= wr + PW'(push);
      level    <= level_nxt;
      out_word <= head_nxt;
      tx_cnt   <= tx_cnt + CNT_W'(pop);
      drop_cnt <= (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_packet_word_tx.sv
// tb_packet_word_tx: vector table, corner sequences and randomized run against a queue model
module tb_packet_word_tx;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  logic        clk = 0;
  logic        rst_n, in_valid, in_ready, in_pkt_vld, flush, out_valid, out_ready;
  logic [7:0]  in_addr, in_data;
  logic [15:0] out_word;
  logic [2:0]  level;
  logic [3:0]  tx_cnt, drop_cnt;
  int          n_tests = 0, n_fail = 0;
  logic [15:0] q[$];
  int          m_tx = 0, m_drop = 0;
  typedef struct {
    logic r, iv; logic [7:0] a, d; logic pv, fl, orr;
    logic ev; logic [15:0] ew; logic [2:0] el; logic [3:0] et, ed;
  } vec_t;
  vec_t tbl[15];

  packet_word_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_pkt_vld(in_pkt_vld), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .level(level),
    .tx_cnt(tx_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle: drive at negedge, check ready, advance model at the edge, check outputs
  task automatic cyc(input logic r, iv, input logic [7:0] a, d, input logic pv, fl, orr);
    logic rdy;
    rst_n = r; in_valid = iv; in_addr = a; in_data = d; in_pkt_vld = pv; flush = fl; out_ready = orr;
    #1;
    rdy = r && !fl && (q.size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (!r) begin
      q.delete(); m_tx = 0; m_drop = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && orr) begin
        void'(q.pop_front());
        m_tx = (m_tx + 1) % 16;
      end
      if (iv && rdy && pv) q.push_back({a, d});
      if (iv && rdy && !pv && m_drop < 15) m_drop++;
    end
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("out_word", {16'd0, out_word}, {16'd0, (q.size() > 0) ? q[0] : 16'h0000});
    chk("level", {29'd0, level}, 32'(q.size()));
    chk("tx_cnt", {28'd0, tx_cnt}, 32'(m_tx));
    chk("drop_cnt", {28'd0, drop_cnt}, 32'(m_drop));
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_addr = 0; in_data = 0; in_pkt_vld = 0; flush = 0; out_ready = 0;
    tbl[0]  = '{0,0,8'h00,8'h00,0,0,0, 0,16'h0000,3'd0,4'd0,4'd0};
    tbl[1]  = '{1,1,8'hA5,8'h3C,1,0,1, 1,16'hA53C,3'd1,4'd0,4'd0};
    tbl[2]  = '{1,0,8'h00,8'h00,0,0,1, 0,16'h0000,3'd0,4'd1,4'd0};
    tbl[3]  = '{1,1,8'h11,8'h22,0,0,0, 0,16'h0000,3'd0,4'd1,4'd1};
    tbl[4]  = '{1,1,8'h11,8'h22,0,0,0, 0,16'h0000,3'd0,4'd1,4'd2};
    tbl[5]  = '{1,1,8'h11,8'h22,0,0,0, 0,16'h0000,3'd0,4'd1,4'd3};
    tbl[6]  = '{1,1,8'h01,8'h02,1,0,0, 1,16'h0102,3'd1,4'd1,4'd3};
    tbl[7]  = '{1,1,8'h03,8'h04,1,0,0, 1,16'h0102,3'd2,4'd1,4'd3};
    tbl[8]  = '{1,1,8'h05,8'h06,1,0,1, 1,16'h0304,3'd2,4'd2,4'd3};
    tbl[9]  = '{1,0,8'h00,8'h00,0,0,1, 1,16'h0506,3'd1,4'd3,4'd3};
    tbl[10] = '{1,1,8'h07,8'h08,1,0,1, 1,16'h0708,3'd1,4'd4,4'd3};
    tbl[11] = '{1,1,8'h09,8'h0A,1,0,0, 1,16'h0708,3'd2,4'd4,4'd3};
    tbl[12] = '{1,1,8'h0B,8'h0C,1,0,0, 1,16'h0708,3'd3,4'd4,4'd3};
    tbl[13] = '{1,1,8'h0D,8'h0E,1,1,1, 0,16'h0000,3'd0,4'd4,4'd3};
    tbl[14] = '{1,0,8'h00,8'h00,0,0,0, 0,16'h0000,3'd0,4'd4,4'd3};
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].a, tbl[i].d, tbl[i].pv, tbl[i].fl, tbl[i].orr);
      chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk("tbl_word", {16'd0, out_word}, {16'd0, tbl[i].ew});
      chk("tbl_level", {29'd0, level}, {29'd0, tbl[i].el});
      chk("tbl_tx", {28'd0, tx_cnt}, {28'd0, tbl[i].et});
      chk("tbl_drop", {28'd0, drop_cnt}, {28'd0, tbl[i].ed});
    end
    // fill past capacity with the consumer stalled, then drain in order
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 8'(8'h10 + i), 8'(8'h20 + i), 1, 0, 0);
      if (i == 3) chk("full_level", {29'd0, level}, 32'd4);
    end
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("order", {16'd0, out_word}, {16'd0, 8'(8'h10 + i), 8'(8'h20 + i)});
      cyc(1, 0, 8'h00, 8'h00, 0, 0, 1);
    end
    chk("drain_tx", {28'd0, tx_cnt}, 32'd4);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    // drop counter saturation
    for (int i = 0; i < 17; i++) cyc(1, 1, 8'h11, 8'h22, 0, 0, 0);
    chk("drop_sat", {28'd0, drop_cnt}, 32'd15);
    // reset with three packets buffered
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h30 + i), 8'h55, 1, 0, 0);
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    cyc(0, 1, 8'h77, 8'h88, 1, 0, 1);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_word", {16'd0, out_word}, 32'd0);
    chk("rst_drop", {28'd0, drop_cnt}, 32'd0);
    rst_n = 1; in_valid = 0; #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
          $urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
